display_bcd_sequencer: RTL

DISPLAY_BCD_SEQUENCER -- requirements
Module: display_bcd_sequencer

---
 rtl/display_bcd_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/display_bcd_sequencer.sv
// ============================================================================
// display_bcd_sequencer : scans display channels, converts each 12-bit sample to BCD
// Rev 1.0
// ============================================================================
`default_nettype none

module display_bcd_sequencer #(
  parameter int DWELL_CYCLES = 1000,
  parameter int NUM_CH       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [2:0]  select,
  input  logic [11:0] mux_in,
  output logic [15:0] bcd_out,
  output logic [2:0]  channel_out,
  output logic        bcd_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CONVERT = 3'd2,
    DONE    = 3'd3,
    DWELL   = 3'd4
  } state_t;

  localparam logic [15:0] c_DWELL_LAST = 16'(DWELL_CYCLES);
  localparam logic [2:0]  c_LAST_CH    = 3'(NUM_CH - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [27:0] r_work;   // [27:12] BCD digits, [11:0] binary being shifted out
  logic [2:0]  r_ch;

  // One double-dabble iteration: correct every digit >= 5, then shift left.
  function automatic logic [27:0] dabble_step(input logic [27:0] w);
    logic [27:0] a;
    a = w;
    for (int i = 0; i < 4; i++) begin
      if (a[12+4*i +: 4] >= 4'd5)
        a[12+4*i +: 4] = a[12+4*i +: 4] + 4'd3;
    end
    return {a[26:0], 1'b0};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_ch        <= '0;
      select      <= '0;
      bcd_out     <= '0;
      channel_out <= '0;
      bcd_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= SETTLE;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        SETTLE: begin
          if (r_cnt == 16'd1) begin
            r_work  <= {16'd0, mux_in};
            r_ch    <= select;
            r_cnt   <= '0;
            r_state <= CONVERT;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        CONVERT: begin
          r_work <= dabble_step(r_work);
          if (r_cnt == 16'd11) begin
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DONE: begin
          bcd_out     <= r_work[27:12];
          channel_out <= r_ch;
          bcd_valid   <= 1'b1;
          r_cnt       <= '0;
          if (enable) begin
            r_state <= DWELL;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        DWELL: begin
          // Dropping enable wins over the channel advance on the final cycle.
          if (!enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else if (r_cnt == c_DWELL_LAST) begin
            select  <= (select == c_LAST_CH) ? 3'd0 : select + 3'd1;
            r_cnt   <= '0;
            r_state <= SETTLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
